// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction field positions, link register
// index and the immediate-extension helper.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned RIDX_W  = 5;
  localparam int unsigned IMM_W   = 16;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RS_MSB  = 25;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_MSB  = 20;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_MSB  = 15;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  localparam int unsigned REG_RA = 31;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // Logical immediates and sltiu are zero-extended; everything else, including
  // unknown opcodes and lui, sign-extends.
  function automatic logic [INSTR_W-1:0] ext_imm(input logic [OP_W-1:0] op,
                                                 input logic [IMM_W-1:0] imm);
    logic [INSTR_W-1:0] res;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI, OP_SLTIU: res = {16'h0000, imm};
      default:                            res = {{16{imm[IMM_W-1]}}, imm};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instr_decoder_if.sv
// Decode-stage bus: fetched instruction, write-back sources and controls in,
// register read data and extended immediate out.
interface instr_decoder_if #(
  parameter int unsigned DATA_W = 32
);
  logic [31:0]       Instruction;
  logic [31:0]       link_addr;
  logic [DATA_W-1:0] ALU_result;
  logic [DATA_W-1:0] mem_data;
  logic              RegWrite;
  logic              RegDst;
  logic              MemtoReg;
  logic              Jal;
  logic [DATA_W-1:0] Read_data_1;
  logic [DATA_W-1:0] Read_data_2;
  logic [DATA_W-1:0] Sign_extend;

  modport master (
    output Instruction, link_addr, ALU_result, mem_data,
    output RegWrite, RegDst, MemtoReg, Jal,
    input  Read_data_1, Read_data_2, Sign_extend
  );

  modport slave (
    input  Instruction, link_addr, ALU_result, mem_data,
    input  RegWrite, RegDst, MemtoReg, Jal,
    output Read_data_1, Read_data_2, Sign_extend
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file: async active-low clear, two combinational read
// ports, one write port; register 0 is hardwired to zero.
module reg_file #(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [$clog2(REG_COUNT)-1:0] raddr_1,
  input  logic [$clog2(REG_COUNT)-1:0] raddr_2,
  output logic [DATA_W-1:0]            rdata_1,
  output logic [DATA_W-1:0]            rdata_2,
  input  logic                         we,
  input  logic [$clog2(REG_COUNT)-1:0] waddr,
  input  logic [DATA_W-1:0]            wdata
);

  localparam int unsigned ADDR_W = $clog2(REG_COUNT);

  logic [DATA_W-1:0] regs [REG_COUNT];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != ADDR_W'(0))) begin
      regs[waddr] <= wdata;
    end
  end

  // No bypass: a same-cycle write is only seen after the committing edge.
  always_comb begin
    rdata_1 = '0;
    rdata_2 = '0;
    if (raddr_1 != ADDR_W'(0)) rdata_1 = regs[raddr_1];
    if (raddr_2 != ADDR_W'(0)) rdata_2 = regs[raddr_2];
  end

endmodule

// File: rtl/instr_decoder.sv
// Decode stage: immediate extender plus write-back destination/data muxes in
// front of the register file.
module instr_decoder
  import mips_pkg::*;
#(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  instr_decoder_if.slave   bus
);

  localparam int unsigned ADDR_W = $clog2(REG_COUNT);

  logic [ADDR_W-1:0] rs_c;
  logic [ADDR_W-1:0] rt_c;
  logic [ADDR_W-1:0] rd_c;
  logic [ADDR_W-1:0] waddr_c;
  logic [DATA_W-1:0] wdata_c;
  logic              we_c;

  always_comb begin
    rs_c = ADDR_W'(bus.Instruction[RS_MSB:RS_LSB]);
    rt_c = ADDR_W'(bus.Instruction[RT_MSB:RT_LSB]);
    rd_c = ADDR_W'(bus.Instruction[RD_MSB:RD_LSB]);
  end

  // Jal overrides both destination and data selection.
  always_comb begin
    we_c    = bus.RegWrite | bus.Jal;
    waddr_c = rt_c;
    wdata_c = bus.ALU_result;
    if (bus.Jal) begin
      waddr_c = ADDR_W'(REG_RA);
      wdata_c = DATA_W'(bus.link_addr);
    end else begin
      if (bus.RegDst)   waddr_c = rd_c;
      if (bus.MemtoReg) wdata_c = bus.mem_data;
    end
  end

  assign bus.Sign_extend = DATA_W'(ext_imm(bus.Instruction[OP_MSB:OP_LSB],
                                           bus.Instruction[IMM_MSB:IMM_LSB]));

  reg_file #(
    .REG_COUNT (REG_COUNT),
    .DATA_W    (DATA_W)
  ) u_reg_file (
    .clock   (clock),
    .reset   (reset),
    .raddr_1 (rs_c),
    .raddr_2 (rt_c),
    .rdata_1 (bus.Read_data_1),
    .rdata_2 (bus.Read_data_2),
    .we      (we_c),
    .waddr   (waddr_c),
    .wdata   (wdata_c)
  );

endmodule
